// File: rtl/fc_mac_seq_if.sv
// Handshake/data bundle for one fc_mac_seq lane: operand stream in, result out.
interface fc_mac_seq_if #(
    parameter int N = 8,
    parameter int L = 17
);
    logic                start;
    logic signed [L-1:0] bias;
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] A;
    logic signed [N-1:0] B;
    logic                out_valid;
    logic                out_ready;
    logic signed [L-1:0] S;
    logic                busy;

    modport master (
        output start, bias, in_valid, A, B, out_ready,
        input  in_ready, out_valid, S, busy
    );

    modport slave (
        input  start, bias, in_valid, A, B, out_ready,
        output in_ready, out_valid, S, busy
    );
endinterface

// File: rtl/fc_mac_seq.sv
// Sequential dot-product engine: K signed NxN products accumulated onto a bias,
// one registered L-bit result per vector with optional ReLU.
module fc_mac_seq #(
    parameter int N    = 8,
    parameter int K    = 3,
    parameter int L    = 2*(N-1)+K,
    parameter int RELU = 0
) (
    input logic         clk,
    input logic         rst,
    fc_mac_seq_if.slave bus
);
    localparam int CW = $clog2(K) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic signed [L-1:0] acc;
    logic [CW-1:0]       cnt;
    logic signed [2*N-1:0] prod;
    logic signed [L-1:0] prod_ext;
    logic signed [L-1:0] sum;
    logic signed [L-1:0] result;
    logic                beat;
    logic                last;
    logic                load;

    // Product, wrapped accumulation and optional ReLU of the running sum
    always_comb begin
        prod     = bus.A * bus.B;
        prod_ext = L'(prod);
        sum      = acc + prod_ext;
        result   = sum;
        if (RELU != 0 && sum[L-1]) begin
            result = '0;
        end
        beat = (state == ACC) && bus.in_valid;
        last = (cnt == CW'(K - 1));
        load = bus.start && ((state == IDLE) || (state == DONE && bus.out_ready));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = ACC;
            ACC:  if (beat && last) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = bus.start ? ACC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake outputs decoded from state alone
    always_comb begin
        bus.in_ready  = (state == ACC);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
    end

    // Accumulator, beat counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            bus.S <= '0;
        end else if (load) begin
            acc <= bus.bias;
            cnt <= '0;
        end else if (beat) begin
            acc <= sum;
            if (last) begin
                cnt   <= '0;
                bus.S <= result;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
